otter_rfile_mp: RTL and testbench

Parametrised multi-read-port register file for the Otter core, successor to the fixed 32x32 two-read-port file. Adds a configurable read-port count, optional same-cycle write-to-read bypass, a hardware reset-clear sequencer (storage has no per-bit reset, so it maps to LUTRAM), and a per-register busy scoreboard for long-latency results. Sits between decode (read ports, reservations) and writeback (write port).

---
 rtl/otter_rfile_pkg.sv | 12 +
 rtl/otter_rfile_scoreboard.sv | 39 +++
 rtl/otter_rfile_mp.sv | 97 +++++++++
 tb/tb_otter_rfile_mp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/otter_rfile_pkg.sv
// Shared types and default sizing for the Otter register file and decode stage.
package otter_rfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rfile_state_t;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

endpackage

// File: rtl/otter_rfile_scoreboard.sv
// Per-register busy bits for long-latency results, with NRD combinational lookups.
module otter_rfile_scoreboard
  import otter_rfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NRD*AW-1:0] lk_addr,
  output logic [NRD-1:0]    lk_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle reserve wins over the write.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    assign lk_busy[k] = busy_q[lk_addr[k*AW +: AW]];
  end

endmodule

// File: rtl/otter_rfile_mp.sv
// Multi-read-port register file: LUTRAM storage, hardware clear sequencer,
// optional write-to-read bypass and a busy scoreboard.
module otter_rfile_mp
  import otter_rfile_pkg::*;
#(
  parameter  int XLEN   = DEF_XLEN,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_r_addr,
  output logic [NRD*XLEN-1:0] o_r_data,
  output logic [NRD-1:0]      o_r_busy,
  input  logic                i_w_en,
  input  logic [AW-1:0]       i_w_addr,
  input  logic [XLEN-1:0]     i_w_data,
  input  logic                i_rsv_en,
  input  logic [AW-1:0]       i_rsv_addr,
  output logic                o_ready
);

  rfile_state_t    state_q;
  rfile_state_t    state_d;
  logic [AW:0]     cnt_q;
  logic            run;
  logic            user_wr;
  logic            user_rsv;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [NRD-1:0]  sb_busy;
  logic [XLEN-1:0] mem [NREGS];

  assign run      = (state_q == RUN);
  assign o_ready  = run;
  assign user_wr  = run && i_w_en && (i_w_addr != '0);
  assign user_rsv = run && i_rsv_en && (i_rsv_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!run) cnt_q <= cnt_q + (AW+1)'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_q == (AW+1)'(NREGS-1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // The clear sequencer borrows the single write port, so storage needs no reset.
  assign wr_en   = !run || user_wr;
  assign wr_addr = run ? i_w_addr : cnt_q[AW-1:0];
  assign wr_data = run ? i_w_data : '0;

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  otter_rfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clr_en   (user_wr),
    .clr_addr (i_w_addr),
    .set_en   (user_rsv),
    .set_addr (i_rsv_addr),
    .lk_addr  (i_r_addr),
    .lk_busy  (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = i_r_addr[k*AW +: AW];
    assign hit  = (BYPASS != 0) && user_wr && (i_w_addr == addr);

    assign o_r_data[k*XLEN +: XLEN] = (!run || addr == '0) ? '0 :
                                      hit                  ? i_w_data :
                                                             mem[addr];
    assign o_r_busy[k] = run && (addr != '0) && !hit && sb_busy[k];
  end

endmodule

// File: tb/tb_otter_rfile_mp.sv
// Randomised bench for otter_rfile_mp: a 4-port bypassing instance and a 2-port
// non-bypassing instance share stimulus and are checked against one reference model.
module tb_otter_rfile_mp;
  import otter_rfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4*AW-1:0]   r_addr;
  logic [4*XLEN-1:0] r_data4;
  logic [3:0]        r_busy4;
  logic              ready4;
  logic [2*XLEN-1:0] r_data2;
  logic [1:0]        r_busy2;
  logic              ready2;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [XLEN-1:0]   w_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;

  logic [XLEN-1:0] mem_m [NREGS];
  bit              busy_m [NREGS];
  bit              ready_m;
  int              edges_m;
  int              check_count = 0;
  int              error_count = 0;

  always #5 clk = ~clk;

  otter_rfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(4), .BYPASS(1)) dut4 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_r_addr   (r_addr),
    .o_r_data   (r_data4),
    .o_r_busy   (r_busy4),
    .i_w_en     (w_en),
    .i_w_addr   (w_addr),
    .i_w_data   (w_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .o_ready    (ready4)
  );

  otter_rfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(2), .BYPASS(0)) dut2 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_r_addr   (r_addr[2*AW-1:0]),
    .o_r_data   (r_data2),
    .o_r_busy   (r_busy2),
    .i_w_en     (w_en),
    .i_w_addr   (w_addr),
    .i_w_data   (w_data),
    .i_rsv_en   (rsv_en),
    .i_rsv_addr (rsv_addr),
    .o_ready    (ready2)
  );

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a, input bit bypass);
    if (!ready_m || a == 0) return '0;
    if (bypass && w_en && w_addr == a) return w_data;
    return mem_m[a];
  endfunction

  function automatic logic [XLEN-1:0] exp_busy(input logic [AW-1:0] a, input bit bypass);
    if (!ready_m || a == 0) return '0;
    if (bypass && w_en && w_addr == a) return '0;
    return {31'd0, busy_m[a]};
  endfunction

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%h expected=%h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    logic [AW-1:0] a;
    checkOutput("ready4", {31'd0, ready4}, {31'd0, ready_m});
    checkOutput("ready2", {31'd0, ready2}, {31'd0, ready_m});
    for (int k = 0; k < 4; k++) begin
      a = r_addr[k*AW +: AW];
      checkOutput($sformatf("data4[%0d] r%0d", k, a), r_data4[k*XLEN +: XLEN], exp_data(a, 1'b1));
      checkOutput($sformatf("busy4[%0d] r%0d", k, a), {31'd0, r_busy4[k]}, exp_busy(a, 1'b1));
    end
    for (int k = 0; k < 2; k++) begin
      a = r_addr[k*AW +: AW];
      checkOutput($sformatf("data2[%0d] r%0d", k, a), r_data2[k*XLEN +: XLEN], exp_data(a, 1'b0));
      checkOutput($sformatf("busy2[%0d] r%0d", k, a), {31'd0, r_busy2[k]}, exp_busy(a, 1'b0));
    end
  endtask

  // Reference behaviour: NREGS edges after release the whole file is zero and
  // usable; afterwards writes store and free, reserves mark busy (reserve last).
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (!ready_m) begin
        edges_m++;
        if (edges_m == NREGS) begin
          ready_m = 1'b1;
          for (int i = 0; i < NREGS; i++) mem_m[i] = '0;
        end
      end else begin
        if (w_en && w_addr != 0) begin
          mem_m[w_addr]  = w_data;
          busy_m[w_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) busy_m[rsv_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                               input logic re, input logic [AW-1:0] ra, input logic [4*AW-1:0] addrs);
    w_en     = we;
    w_addr   = wa;
    w_data   = wd;
    rsv_en   = re;
    rsv_addr = ra;
    r_addr   = addrs;
    #2;
    checkAll();
    tick();
  endtask

  task automatic doReset(input int hold);
    rst_n   = 1'b0;
    w_en    = 1'b0;
    rsv_en  = 1'b0;
    ready_m = 1'b0;
    edges_m = 0;
    for (int i = 0; i < NREGS; i++) busy_m[i] = 1'b0;
    #1;
    checkAll();
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [4*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  initial begin
    int b;
    logic [AW-1:0] wa;
    logic [4*AW-1:0] ra;

    rst_n = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; r_addr = '0;
    ready_m = 1'b0; edges_m = 0;
    for (int i = 0; i < NREGS; i++) begin mem_m[i] = '0; busy_m[i] = 1'b0; end
    tick();
    doReset(3);

    // Abort the clear after ten edges, with writes to r5 that must be ignored.
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, pack4(5, i, 31 - i, 5));
    doReset(2);
    for (int i = 0; i < NREGS; i++)
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, AW'(i), pack4(5, i, 0, 31));
    for (int i = 0; i < NREGS; i += 4)
      applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(i, i + 1, i + 2, i + 3));

    applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, pack4(0, 0, 1, 0));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(0, 5, 0, 0));

    for (int i = 1; i < NREGS; i++)
      applyStimulus(1'b1, AW'(i), 32'h1000_0000 + i, 1'b0, '0, pack4(i, i - 1, 0, 31));
    for (int i = 0; i < 16; i++) begin
      b = $urandom_range(0, 30);
      applyStimulus(1'b0, '0, '0, 1'b0, '0,
                    pack4(1 + b, 1 + (b + 8) % 31, 1 + (b + 16) % 31, 1 + (b + 24) % 31));
    end

    applyStimulus(1'b1, 5'd7, 32'hCAFEBABE, 1'b0, '0, pack4(7, 7, 6, 7));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(7, 7, 7, 8));

    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, pack4(9, 9, 9, 9));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(9, 9, 9, 9));
    applyStimulus(1'b1, 5'd9, 32'h12345678, 1'b0, '0, pack4(9, 9, 9, 9));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(9, 9, 9, 9));
    applyStimulus(1'b1, 5'd9, 32'h0BAD_F00D, 1'b1, 5'd9, pack4(9, 9, 9, 9));
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, pack4(9, 9, 0, 0));
    applyStimulus(1'b0, '0, '0, 1'b0, '0, pack4(0, 9, 0, 9));

    for (int n = 0; n < 400; n++) begin
      wa = AW'($urandom_range(0, NREGS - 1));
      ra = {AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31))};
      if ($urandom_range(0, 2) == 0) ra[AW-1:0] = wa;
      if ($urandom_range(0, 2) == 0) ra[AW +: AW] = wa;
      if (n == 250) doReset(1);
      applyStimulus($urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 2) == 0,
                    AW'($urandom_range(0, NREGS - 1)), ra);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
